// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, redirect handling and the IF/ID register.
// Instruction memory is external with asynchronous read.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        misalign_d
);

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;
  logic        r_misalign_d;
  logic        r_misalign_f;
  logic [31:0] w_pc_plus4_f;
  logic [31:0] w_pc_redirect;
  logic        w_load_d;
  logic        w_unused;

  assign w_pc_plus4_f  = r_pc_f + 32'd4;
  assign w_pc_redirect = {pc_target_e[31:2], 2'b00};
  assign w_load_d      = !flush_d && !stall_d;
  // JALR clears bit 0 of the target, so it carries no information here
  assign w_unused      = pc_target_e[0];

  // A redirect beats stall_f so a taken branch is never lost
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f       <= RESET_PC;
      r_misalign_f <= 1'b0;
    end else if (pc_src_e) begin
      r_pc_f       <= w_pc_redirect;
      r_misalign_f <= pc_target_e[1];
    end else begin
      if (!stall_f) begin
        r_pc_f <= w_pc_plus4_f;
      end
      if (w_load_d) begin
        r_misalign_f <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_d) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
      r_misalign_d <= 1'b0;
    end else if (!stall_d) begin
      r_instr_d    <= imem_rdata;
      r_pc_d       <= r_pc_f;
      r_pc_plus4_d <= w_pc_plus4_f;
      r_valid_d    <= 1'b1;
      r_misalign_d <= r_misalign_f;
    end
  end

  assign imem_addr  = r_pc_f;
  assign pc_f       = r_pc_f;
  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;
  assign misalign_d = r_misalign_d;

endmodule
